// File: rtl/layer_serializer.sv
// layer_serializer
// Gathers one layer's parallel neuron outputs on a single strobe and replays
// them one element per transfer into the next layer's shared neuron input.
// A one-deep pending buffer holds a second vector while the first drains.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | shift buffer empty, waiting for an inValid_i strobe
// SHIFT | shift buffer loaded, presenting element cnt on outData_o
module layer_serializer #(
    parameter int NEURON_NUM = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             inValid_i,
    input  logic [NEURON_NUM*DATA_WIDTH-1:0] inData_i,
    input  logic                             outReady_i,
    output logic [DATA_WIDTH-1:0]            outData_o,
    output logic                             outValid_o,
    output logic                             layerDone_o,
    output logic                             busy_o,
    output logic                             overrun_o
);

    // $clog2(2) is already 1, so only NEURON_NUM < 2 would need the floor
    localparam int CNT_W = (NEURON_NUM > 2) ? $clog2(NEURON_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NEURON_NUM - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // element k of a vector sits at index [k], matching inData_i[k*DATA_WIDTH +: DATA_WIDTH]
    typedef logic [NEURON_NUM-1:0][DATA_WIDTH-1:0] vec_t;

    state_t                 stateQ, stateD;
    logic [CNT_W-1:0]       cntQ, cntD;
    logic [CNT_W-1:0]       cntInc;
    vec_t                   sbQ, sbD;
    vec_t                   pbQ, pbD;
    vec_t                   inVec;
    logic                   pendVQ, pendVD;
    logic [DATA_WIDTH-1:0]  dataQ, dataD;
    logic                   doneQ, doneD;
    logic                   overQ, overD;
    logic                   busyQ, busyD;
    logic                   xfer;
    logic                   lastXfer;

    assign inVec    = inData_i;
    assign xfer     = (stateQ == SHIFT) & outReady_i;
    assign lastXfer = xfer & (cntQ == LAST_IDX);
    assign cntInc   = cntQ + CNT_W'(1);

    // Next-state, buffer movement and next values of the registered outputs
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        sbD    = sbQ;
        pbD    = pbQ;
        pendVD = pendVQ;
        dataD  = dataQ;
        doneD  = 1'b0;
        overD  = overQ;

        case (stateQ)
            IDLE: begin
                if (inValid_i) begin
                    sbD    = inVec;
                    cntD   = '0;
                    dataD  = inVec[0];
                    stateD = SHIFT;
                end
            end
            SHIFT: begin
                if (lastXfer) begin
                    // Reloading on the last transfer edge is what keeps
                    // back-to-back vectors free of bubble cycles.
                    doneD = 1'b1;
                    cntD  = '0;
                    if (pendVQ) begin
                        sbD   = pbQ;
                        dataD = pbQ[0];
                        if (inValid_i) begin
                            pbD = inVec;
                        end else begin
                            pendVD = 1'b0;
                        end
                    end else if (inValid_i) begin
                        sbD   = inVec;
                        dataD = inVec[0];
                    end else begin
                        stateD = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        cntD  = cntInc;
                        dataD = sbQ[cntInc];
                    end
                    if (inValid_i) begin
                        if (!pendVQ) begin
                            pbD    = inVec;
                            pendVD = 1'b1;
                        end else begin
                            // both buffers full: new vector is lost, PB kept
                            overD = 1'b1;
                        end
                    end
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase

        busyD = (stateD == SHIFT) | pendVD;
    end

    // Control state and registered outputs, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            pendVQ <= 1'b0;
            dataQ  <= '0;
            doneQ  <= 1'b0;
            overQ  <= 1'b0;
            busyQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            pendVQ <= pendVD;
            dataQ  <= dataD;
            doneQ  <= doneD;
            overQ  <= overD;
            busyQ  <= busyD;
        end
    end

    // Vector storage carries no reset; its contents are qualified by state/pendV
    always_ff @(posedge clk_i) begin
        sbQ <= sbD;
        pbQ <= pbD;
    end

    assign outData_o   = dataQ;
    assign outValid_o  = (stateQ == SHIFT);
    assign layerDone_o = doneQ;
    assign busy_o      = busyQ;
    assign overrun_o   = overQ;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer with a queue-based reference model.
module tb_layer_serializer;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             inValid_i = 1'b0;
    logic [N*W-1:0]   inData_i = '0;
    logic             outReady_i = 1'b0;
    logic [W-1:0]     outData_o;
    logic             outValid_o;
    logic             layerDone_o;
    logic             busy_o;
    logic             overrun_o;

    int nVec = 0;
    int nErr = 0;

    always #5 clk_i = ~clk_i;

    layer_serializer #(.NEURON_NUM(N), .DATA_WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .inValid_i  (inValid_i),
        .inData_i   (inData_i),
        .outReady_i (outReady_i),
        .outData_o  (outData_o),
        .outValid_o (outValid_o),
        .layerDone_o(layerDone_o),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o)
    );

    // Reference model: vectors held (0..2), elements still owed, position in vector
    int           holding;
    int           pos;
    logic [W-1:0] expQ[$];
    bit           expDone;
    bit           expOverrun;
    bit           mXfer;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            holding    = 0;
            pos        = 0;
            expQ.delete();
            expDone    = 0;
            expOverrun = 0;
        end else begin
            mXfer   = (holding > 0) && outReady_i;
            expDone = 0;
            if (mXfer) begin
                void'(expQ.pop_front());
                if (pos == N - 1) begin
                    pos     = 0;
                    holding = holding - 1;
                    expDone = 1;
                end else begin
                    pos = pos + 1;
                end
            end
            if (inValid_i) begin
                if (holding < 2) begin
                    for (int k = 0; k < N; k++) expQ.push_back(inData_i[k*W +: W]);
                    holding = holding + 1;
                end else begin
                    expOverrun = 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Observed stream and done pulses, for the hand-computed checks
    logic [W-1:0] logQ[$];
    int           doneCnt;

    always @(negedge clk_i) begin
        chk("outValid", int'(outValid_o), int'(holding > 0));
        chk("busy", int'(busy_o), int'(holding > 0));
        chk("layerDone", int'(layerDone_o), int'(expDone));
        chk("overrun", int'(overrun_o), int'(expOverrun));
        if (holding > 0 && expQ.size() > 0)
            chk("outData", int'(outData_o), int'(expQ[0]));
        else if (!rst_ni)
            chk("outDataRst", int'(outData_o), 0);
        if (rst_ni && outValid_o && outReady_i) logQ.push_back(outData_o);
        if (layerDone_o) doneCnt++;
    end

    function automatic logic [N*W-1:0] vec(input int first);
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(first + k);
        return v;
    endfunction

    task automatic drive(input logic v, input logic [N*W-1:0] d, input logic r);
        @(posedge clk_i);
        #1;
        inValid_i  = v;
        inData_i   = d;
        outReady_i = r;
    endtask

    task automatic clearLog();
        logQ.delete();
        doneCnt = 0;
    endtask

    task automatic checkSeq(input string nm, input int first, input int n);
        bit ok;
        ok = (logQ.size() == n);
        for (int i = 0; i < logQ.size() && i < n; i++)
            if (int'(logQ[i]) != first + i) ok = 0;
        nVec++;
        if (!ok) begin
            nErr++;
            $display("FAIL %s: got %0d elements starting %0h, expected %0d elements %0h..%0h",
                     nm, logQ.size(), (logQ.size() > 0) ? int'(logQ[0]) : -1,
                     n, first, first + n - 1);
        end
    endtask

    task automatic pulseReset();
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        doneCnt = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("resetBusy", int'(busy_o), 0);
        chk("resetData", int'(outData_o), 0);
        rst_ni = 1'b1;

        // single vector {4,3,2,1}
        clearLog();
        drive(1'b1, vec(1), 1'b1);
        repeat (6) drive(1'b0, '0, 1'b1);
        checkSeq("single", 1, 4);
        chk("singleDone", doneCnt, 1);
        chk("singleIdle", int'(busy_o), 0);

        // backpressure
        clearLog();
        drive(1'b1, vec(1), 1'b1);
        foreach (pat[i]) drive(1'b0, '0, pat[i][0]);
        repeat (4) drive(1'b0, '0, 1'b1);
        checkSeq("backpressure", 1, 4);
        chk("bpDone", doneCnt, 1);

        // pending buffer: second vector two cycles after the first
        clearLog();
        drive(1'b1, vec(1), 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, vec(5), 1'b1);
        repeat (10) drive(1'b0, '0, 1'b1);
        checkSeq("pending", 1, 8);
        chk("pendDone", doneCnt, 2);
        chk("pendNoOverrun", int'(overrun_o), 0);

        // overrun: third vector while SB drains and PB is full
        clearLog();
        drive(1'b1, vec(1), 1'b1);
        drive(1'b1, vec(5), 1'b1);
        drive(1'b1, vec(9), 1'b1);
        repeat (12) drive(1'b0, '0, 1'b1);
        checkSeq("overrun", 1, 8);
        chk("overrunSet", int'(overrun_o), 1);
        repeat (3) drive(1'b0, '0, 1'b1);
        chk("overrunSticky", int'(overrun_o), 1);
        pulseReset();
        chk("overrunCleared", int'(overrun_o), 0);

        // same-cycle reload: strobe coincides with transfer of element 4
        clearLog();
        drive(1'b1, vec(1), 1'b1);
        drive(1'b1, vec(5), 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, vec(9), 1'b1);
        repeat (16) drive(1'b0, '0, 1'b1);
        checkSeq("reload", 1, 12);
        chk("reloadDone", doneCnt, 3);
        chk("reloadNoDrop", int'(overrun_o), 0);

        // async reset after element 2 transfers, between edges
        clearLog();
        drive(1'b1, vec(1), 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("asyncValid", int'(outValid_o), 0);
        chk("asyncBusy", int'(busy_o), 0);
        chk("asyncData", int'(outData_o), 0);
        chk("asyncDone", int'(layerDone_o), 0);
        checkSeq("preReset", 1, 2);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        clearLog();
        drive(1'b1, vec(10), 1'b1);
        repeat (6) drive(1'b0, '0, 1'b1);
        checkSeq("postReset", 10, 4);
        chk("postResetDone", doneCnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
